serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_bit.sv | 16 +
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the legal operand-width range.
package serial_adder_pkg;

   localparam int unsigned SA_WIDTH_MIN = 2;
   localparam int unsigned SA_WIDTH_MAX = 64;

   typedef enum logic [1:0] {
      SA_IDLE = 2'd0,
      SA_RUN  = 2'd1,
      SA_DONE = 2'd2
   } sa_state_t;

   function automatic bit sa_width_ok(input int unsigned w);
      return (w >= SA_WIDTH_MIN) && (w <= SA_WIDTH_MAX);
   endfunction

endpackage

// File: rtl/serial_adder_bit.sv
// Combinational 1-bit full-adder cell used by the serial adder.
module serial_adder_bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   // Sum is the parity of the inputs, carry is their majority.
   always_comb begin
      s  = a ^ b ^ ci;
      co = (a & b) | (a & ci) | (b & ci);
   end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {co, sum} = a + b + ci, one bit per clock, LSB first.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned      CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

   if (!sa_width_ok(WIDTH)) begin : g_width_check
      $error("serial_adder: WIDTH out of legal range");
   end

   sa_state_t        state, state_n;
   logic [WIDTH-1:0] a_sh, b_sh, s_sh;
   logic             c;
   logic [CW-1:0]    cnt;
   logic             load, shift, finish;
   logic             s_bit, c_next;

   serial_adder_bit u_bit (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (c),
      .s  (s_bit),
      .co (c_next)
   );

   // State register; reset has priority over any start request.
   always_ff @(posedge clk) begin
      if (rst) state <= SA_IDLE;
      else     state <= state_n;
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_n = state;
      load    = 1'b0;
      shift   = 1'b0;
      finish  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         SA_IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = SA_RUN;
            end
         end
         SA_RUN: begin
            busy  = 1'b1;
            shift = 1'b1;
            if (cnt == LAST) begin
               finish  = 1'b1;
               state_n = SA_DONE;
            end
         end
         SA_DONE: begin
            done = 1'b1;
            if (start) begin
               load    = 1'b1;
               state_n = SA_RUN;
            end else begin
               state_n = SA_IDLE;
            end
         end
         default: state_n = SA_IDLE;
      endcase
   end

   // Operand/sum shift registers, carry and bit counter.
   // sum/co are separate holding registers loaded from the final bit so the
   // visible result only changes on DONE entry, not while the next op shifts.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh <= '0;
         b_sh <= '0;
         s_sh <= '0;
         c    <= 1'b0;
         cnt  <= '0;
         sum  <= '0;
         co   <= 1'b0;
      end else if (load) begin
         a_sh <= a;
         b_sh <= b;
         c    <= ci;
         cnt  <= '0;
      end else if (shift) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         s_sh <= {s_bit, s_sh[WIDTH-1:1]};
         c    <= c_next;
         cnt  <= cnt + CW'(1);
         if (finish) begin
            sum <= {s_bit, s_sh[WIDTH-1:1]};
            co  <= c_next;
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   // Overflow: carry into the MSB (current c on the final edge) XOR carry out.
   always_ff @(posedge clk) begin
      if (rst)                  ovf <= 1'b0;
      else if (shift && finish) ovf <= c ^ c_next;
   end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8); table vectors plus
// hand-written control sequences, results checked through a scoreboard.
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         ci = 1'b0;
   logic         busy, done, co;
   logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .ci    (ci),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .co    (co)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } exp_t;

   exp_t         sb[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   int           cyc = 0;
   int           last_done = 0;
   int           prev_done = 0;
   logic [W-1:0] held_sum = '0;
   logic         held_co = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      exp_t       e;
      logic [W:0] t;
      t    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      e.s  = t[W-1:0];
      e.co = t[W];
      e.ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
      return e;
   endfunction

   // Scoreboard consumer: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'(done), 64'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sum", 64'(sum), 64'(e.s));
            check("co", 64'(co), 64'(e.co));
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf", 64'(ovf), 64'(e.ov));
`endif
            held_sum  = e.s;
            held_co   = e.co;
            prev_done = last_done;
            last_done = cyc;
         end
      end
   end

   // Called at a negedge; returns at the negedge inside the DONE cycle.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input exp_t e, input bit idle_after);
      start = 1'b1; a = x; b = y; ci = c;
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0; a = $urandom; b = $urandom; ci = 1'($urandom);
      for (int unsigned k = 0; k < W; k++) begin
         @(negedge clk);
         check("busy_run", 64'({busy, done}), 64'(2'b10));
         check("sum_held", 64'({held_co, held_sum}), 64'({co, sum}));
      end
      @(negedge clk);
      check("done_cycle", 64'({busy, done}), 64'(2'b01));
      if (idle_after) begin
         @(negedge clk);
         check("done_pulse_end", 64'({busy, done}), 64'(2'b00));
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 30) begin
         @(negedge clk);
         n++;
      end
   endtask

   vec_t vecs[9];

   initial begin
      int   n;
      exp_t e;

      vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_outputs", 64'({busy, done, co, sum}), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
      check("reset_ovf", 64'(ovf), 64'(0));
`endif

      // Table vectors, idle cycle between each.
      for (int i = 0; i < 9; i++) begin
         e.s = vecs[i].s; e.co = vecs[i].co; e.ov = vecs[i].ov;
         run_op(vecs[i].a, vecs[i].b, vecs[i].ci, e, 1'b1);
      end

      // Back-to-back random operands: start issued in each DONE cycle.
      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] x, y;
         logic         c;
         x = W'($urandom); y = W'($urandom); c = 1'($urandom);
         run_op(x, y, c, model(x, y, c), 1'b0);
      end
      #1 check("b2b_spacing", 64'(last_done - prev_done), 64'(W + 1));
      @(negedge clk);
      check("b2b_idle", 64'({busy, done}), 64'(0));

      // Start pulsed during RUN edge 3 must be ignored.
      start = 1'b1; a = 8'h35; b = 8'h4A; ci = 1'b0;
      sb.push_back(model(8'h35, 8'h4A, 1'b0));
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; a = 8'hFF; b = 8'hFF; ci = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      wait_done(n);
      check("ignore_start_latency", 64'(n), 64'(5));
      repeat (12) @(negedge clk);
      check("ignore_start_no_queue", 64'({busy, done}), 64'(0));

      // Reset sampled at RUN edge 4 discards the partial result.
      start = 1'b1; a = 8'h12; b = 8'h34; ci = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midop_reset", 64'({busy, done, co, sum}), 64'(0));
      rst = 1'b0;
      held_sum = '0; held_co = 1'b0;
      repeat (12) @(negedge clk);
      check("midop_reset_idle", 64'({busy, done}), 64'(0));
      run_op(8'h81, 8'h7E, 1'b1, model(8'h81, 8'h7E, 1'b1), 1'b1);

      // Reset and start together: reset wins.
      rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h02;
      @(negedge clk);
      check("rst_beats_start", 64'({busy, done, co, sum}), 64'(0));
      rst = 1'b0; start = 1'b0;
      held_sum = '0; held_co = 1'b0;
      repeat (12) @(negedge clk);
      check("rst_start_idle", 64'({busy, done}), 64'(0));

      check("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
